// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Two-master request/grant/read-response bus presented to the
//               RAM arbiter. The masters drive requests and write data; the
//               arbiter returns grants and read responses.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  // Master 0 (core LSU)
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  // Master 1 (debug loader)
  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata
  );

  // Requester side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-master arbiter for a simple dual-port RAM (one write port,
//               one read port). Each port is arbitrated independently with
//               round-robin on contention. Grants are combinational; read data
//               returns one cycle after grant, with write-to-read bypass when
//               both ports hit the same address in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus,
  // RAM write port
  output logic          ram_w_en_o,
  output logic [AW-1:0] ram_w_addr_o,
  output logic [DW-1:0] ram_w_data_o,
  // RAM read port
  output logic          ram_r_en_o,
  output logic [AW-1:0] ram_r_addr_o,
  input  logic [DW-1:0] ram_r_data_i
);

  // Per-port candidates; reset forces every candidate low so nothing is granted
  logic wr_cand0_w, wr_cand1_w, rd_cand0_w, rd_cand1_w;
  logic wr_any_w, rd_any_w;
  logic wr_sel_w, rd_sel_w;   // granted master index per port

  // Round-robin history, read-response tracking and bypass storage
  logic          wr_last_q, wr_last_d;
  logic          rd_last_q, rd_last_d;
  logic          owner_q, owner_d;
  logic          rvalid_q, rvalid_d;
  logic          byp_q, byp_d;
  logic [DW-1:0] byp_data_q, byp_data_d;

  assign wr_cand0_w = rst_n & bus.m0_req &  bus.m0_we;
  assign wr_cand1_w = rst_n & bus.m1_req &  bus.m1_we;
  assign rd_cand0_w = rst_n & bus.m0_req & ~bus.m0_we;
  assign rd_cand1_w = rst_n & bus.m1_req & ~bus.m1_we;

  assign wr_any_w = wr_cand0_w | wr_cand1_w;
  assign rd_any_w = rd_cand0_w | rd_cand1_w;

  // On contention the master that did not win last time gets the port;
  // otherwise the sole candidate (index defaults to 0 when idle).
  assign wr_sel_w = (wr_cand0_w & wr_cand1_w) ? ~wr_last_q : wr_cand1_w;
  assign rd_sel_w = (rd_cand0_w & rd_cand1_w) ? ~rd_last_q : rd_cand1_w;

  // A master's we selects exactly one port, so it can hold at most one grant
  assign bus.m0_gnt = (wr_any_w & ~wr_sel_w) | (rd_any_w & ~rd_sel_w);
  assign bus.m1_gnt = (wr_any_w &  wr_sel_w) | (rd_any_w &  rd_sel_w);

  // RAM port drive: granted master, else master 0 so the muxes never latch
  assign ram_w_en_o   = wr_any_w;
  assign ram_w_addr_o = (wr_any_w & wr_sel_w) ? bus.m1_addr  : bus.m0_addr;
  assign ram_w_data_o = (wr_any_w & wr_sel_w) ? bus.m1_wdata : bus.m0_wdata;
  assign ram_r_en_o   = rd_any_w;
  assign ram_r_addr_o = (rd_any_w & rd_sel_w) ? bus.m1_addr  : bus.m0_addr;

  // Read response is routed to the registered owner only
  assign bus.m0_rvalid = rvalid_q & ~owner_q;
  assign bus.m1_rvalid = rvalid_q &  owner_q;
  assign bus.m0_rdata  = byp_q ? byp_data_q : ram_r_data_i;
  assign bus.m1_rdata  = byp_q ? byp_data_q : ram_r_data_i;

  // Next-state: history follows each grant; read tracking rewritten every read
  always_comb begin
    wr_last_d  = wr_last_q;
    rd_last_d  = rd_last_q;
    owner_d    = owner_q;
    rvalid_d   = rd_any_w;
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    if (wr_any_w) begin
      wr_last_d = wr_sel_w;
    end
    if (rd_any_w) begin
      rd_last_d  = rd_sel_w;
      owner_d    = rd_sel_w;
      // Same-address write this cycle: RAM would return stale data next cycle
      byp_d      = wr_any_w && (ram_w_addr_o == ram_r_addr_o);
      byp_data_d = ram_w_data_o;
    end
  end

  // State registers; reset makes master 0 win the first contention on each port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last_q  <= 1'b1;
      rd_last_q  <= 1'b1;
      owner_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_last_q  <= wr_last_d;
      rd_last_q  <= rd_last_d;
      owner_q    <= owner_d;
      rvalid_q   <= rvalid_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter: directed vector table
//               plus hand-written reset and streaming sequences, with a
//               behavioural 1-cycle-latency RAM attached to the RAM ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ram_w_en, ram_r_en;
  logic [11:0] ram_w_addr, ram_r_addr;
  logic [31:0] ram_w_data, ram_r_data;

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter_if #(.DW(32), .AW(12)) bus ();

  ram_arbiter #(.DW(32), .AW(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ram_w_en_o   (ram_w_en),
    .ram_w_addr_o (ram_w_addr),
    .ram_w_data_o (ram_w_data),
    .ram_r_en_o   (ram_r_en),
    .ram_r_addr_o (ram_r_addr),
    .ram_r_data_i (ram_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read-during-write returns old contents
  logic [31:0] mem [0:4095];

  function automatic logic [31:0] preload(int k);
    if (k == 12'h001) return 32'h0000_00A1;
    if (k == 12'h002) return 32'h0000_00B2;
    if (k == 12'h030) return 32'h3030_3030;
    if (k >= 12'h100 && k < 12'h108) return 32'h1000 + 32'(k - 12'h100);
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4096; k++) mem[k] <= preload(k);
      ram_r_data <= 32'h0;
    end else begin
      if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
      if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    end
  end

  typedef struct packed {
    logic        m0_req; logic m0_we; logic [11:0] m0_addr; logic [31:0] m0_wdata;
    logic        m1_req; logic m1_we; logic [11:0] m1_addr; logic [31:0] m1_wdata;
    logic        g0; logic g1; logic wen; logic ren;
    logic [11:0] waddr; logic [11:0] raddr; logic [31:0] wdata;
    logic        rv0; logic rv1; logic [31:0] rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r0, logic w0, logic [11:0] a0, logic [31:0] d0,
                       logic r1, logic w1, logic [11:0] a1, logic [31:0] d1);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, " m0_gnt"},    32'(bus.m0_gnt),    32'h0);
    chk({tag, " m1_gnt"},    32'(bus.m1_gnt),    32'h0);
    chk({tag, " ram_w_en"},  32'(ram_w_en),      32'h0);
    chk({tag, " ram_r_en"},  32'(ram_r_en),      32'h0);
    chk({tag, " m0_rvalid"}, 32'(bus.m0_rvalid), 32'h0);
    chk({tag, " m1_rvalid"}, 32'(bus.m1_rvalid), 32'h0);
  endtask

  task automatic check_vec(int i, vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    chk({t, " m0_gnt"},     32'(bus.m0_gnt),    32'(v.g0));
    chk({t, " m1_gnt"},     32'(bus.m1_gnt),    32'(v.g1));
    chk({t, " ram_w_en"},   32'(ram_w_en),      32'(v.wen));
    chk({t, " ram_r_en"},   32'(ram_r_en),      32'(v.ren));
    chk({t, " ram_w_addr"}, 32'(ram_w_addr),    32'(v.waddr));
    chk({t, " ram_r_addr"}, 32'(ram_r_addr),    32'(v.raddr));
    chk({t, " ram_w_data"}, ram_w_data,         v.wdata);
    chk({t, " m0_rvalid"},  32'(bus.m0_rvalid), 32'(v.rv0));
    chk({t, " m1_rvalid"},  32'(bus.m1_rvalid), 32'(v.rv1));
    if (v.rv0) chk({t, " m0_rdata"}, bus.m0_rdata, v.rdata);
    if (v.rv1) chk({t, " m1_rdata"}, bus.m1_rdata, v.rdata);
  endtask

  initial begin
    //          m0: req  we    addr     wdata          m1: req  we    addr     wdata          g0    g1    wen   ren   waddr    raddr    wdata          rv0   rv1   rdata
    // Both read after reset: m0, m1, m0
    vecs[0]  = '{1'b1,1'b0,12'h001,32'h0,        1'b1,1'b0,12'h002,32'h0,        1'b1,1'b0,1'b0,1'b1,12'h001,12'h001,32'h0,        1'b0,1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,12'h001,32'h0,        1'b1,1'b0,12'h002,32'h0,        1'b0,1'b1,1'b0,1'b1,12'h001,12'h002,32'h0,        1'b1,1'b0,32'h0000_00A1};
    vecs[2]  = '{1'b1,1'b0,12'h001,32'h0,        1'b1,1'b0,12'h002,32'h0,        1'b1,1'b0,1'b0,1'b1,12'h001,12'h001,32'h0,        1'b0,1'b1,32'h0000_00B2};
    // m0 write then read back
    vecs[3]  = '{1'b1,1'b1,12'h010,32'hDEADBEEF, 1'b0,1'b0,12'h0AA,32'h0,        1'b1,1'b0,1'b1,1'b0,12'h010,12'h010,32'hDEADBEEF, 1'b1,1'b0,32'h0000_00A1};
    vecs[4]  = '{1'b1,1'b0,12'h010,32'h0,        1'b0,1'b0,12'h0AA,32'h0,        1'b1,1'b0,1'b0,1'b1,12'h010,12'h010,32'h0,        1'b0,1'b0,32'h0};
    vecs[5]  = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,32'h0,        1'b1,1'b0,32'hDEADBEEF};
    // Same-address write/read: bypass returns new data
    vecs[6]  = '{1'b1,1'b1,12'h020,32'h12345678, 1'b1,1'b0,12'h020,32'h0,        1'b1,1'b1,1'b1,1'b1,12'h020,12'h020,32'h12345678, 1'b0,1'b0,32'h0};
    vecs[7]  = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,32'h0,        1'b0,1'b1,32'h12345678};
    // Different-address write/read: old RAM data, write lands
    vecs[8]  = '{1'b1,1'b0,12'h030,32'h0,        1'b1,1'b1,12'h031,32'hCAFEF00D, 1'b1,1'b1,1'b1,1'b1,12'h031,12'h030,32'hCAFEF00D, 1'b0,1'b0,32'h0};
    vecs[9]  = '{1'b1,1'b0,12'h031,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b1,1'b0,1'b0,1'b1,12'h031,12'h031,32'h0,        1'b1,1'b0,32'h3030_3030};
    vecs[10] = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,32'h0,        1'b1,1'b0,32'hCAFEF00D};
    // Write contention (wr_last=1 -> m0 then m1)
    vecs[11] = '{1'b1,1'b1,12'h040,32'h11,       1'b1,1'b1,12'h041,32'h22,       1'b1,1'b0,1'b1,1'b0,12'h040,12'h040,32'h11,       1'b0,1'b0,32'h0};
    vecs[12] = '{1'b1,1'b1,12'h040,32'h11,       1'b1,1'b1,12'h041,32'h22,       1'b0,1'b1,1'b1,1'b0,12'h041,12'h040,32'h22,       1'b0,1'b0,32'h0};
    // Read contention with rd_last=0 -> m1 wins
    vecs[13] = '{1'b1,1'b0,12'h040,32'h0,        1'b1,1'b0,12'h041,32'h0,        1'b0,1'b1,1'b0,1'b1,12'h040,12'h041,32'h0,        1'b0,1'b0,32'h0};
    vecs[14] = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,32'h0,        1'b0,1'b1,32'h22};

    // Reset held with both masters requesting: nothing may be granted
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 12'h001, 32'h0, 1'b1, 1'b1, 12'h002, 32'h5);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk_quiet($sformatf("reset%0d", c));
    end

    // Vector table; reset released in the same cycle as the first vector
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      drive(vecs[i].m0_req, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_wdata,
            vecs[i].m1_req, vecs[i].m1_we, vecs[i].m1_addr, vecs[i].m1_wdata);
      #1 check_vec(i, vecs[i]);
    end

    // Read granted to m1, then reset right after the grant edge
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0);
    #1 chk("rst_seq m1_gnt", 32'(bus.m1_gnt), 32'h1);
    @(posedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 12'h001, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0);
    #2 chk_quiet("rst_seq_a");
    @(negedge clk);
    #1 chk_quiet("rst_seq_b");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_seq rel m0_gnt", 32'(bus.m0_gnt), 32'h1);
    chk("rst_seq rel m1_gnt",    32'(bus.m1_gnt),    32'h0);
    chk("rst_seq rel m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    chk("rst_seq rel m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1 chk("rst_seq m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    chk("rst_seq m0_rdata",  bus.m0_rdata,        32'h0000_00A1);
    chk("rst_seq m1_rvalid", 32'(bus.m1_rvalid),  32'h0);

    // m1 streaming reads, one per cycle, with m0 idle
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h100 + 12'(i), 32'h0);
      else       drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
      #1;
      if (i < 8) chk($sformatf("stream%0d m1_gnt", i), 32'(bus.m1_gnt), 32'h1);
      chk($sformatf("stream%0d m0_rvalid", i), 32'(bus.m0_rvalid), 32'h0);
      chk($sformatf("stream%0d m1_rvalid", i), 32'(bus.m1_rvalid), (i > 0) ? 32'h1 : 32'h0);
      if (i > 0) chk($sformatf("stream%0d m1_rdata", i), bus.m1_rdata, 32'h1000 + 32'(i - 1));
    end
    @(negedge clk);
    #1 chk("stream end m1_rvalid", 32'(bus.m1_rvalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DW, default 32: data width in bits.
REQ-002 Parameter AW, default 12: address width in bits (word address).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 m0_req / m1_req  input  1  access request from master 0 (core LSU) / master 1 (debug loader); held high until granted.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read; valid while req high.
REQ-007 m0_addr / m1_addr  input  AW  word address.
REQ-008 m0_wdata / m1_wdata  input  DW  write data.
REQ-009 m0_gnt / m1_gnt  output  1  request accepted this cycle.
REQ-010 m0_rvalid / m1_rvalid  output  1  read data valid for that master.
REQ-011 m0_rdata / m1_rdata  output  DW  read data.
REQ-012 ram_w_en, ram_w_addr, ram_w_data  output  1/AW/DW  write port to RAM.
REQ-013 ram_r_en, ram_r_addr  output  1/AW  read port to RAM.
REQ-014 ram_r_data  input  DW  RAM read data, valid one cycle after ram_r_en.

Function
REQ-015 Read port and write port SHALL be arbitrated independently; a read from one master and a write from the other SHALL both be granted in the same cycle.
REQ-016 Per port, candidates = masters with req high and we matching that port (we=1 write, we=0 read).
REQ-017 One candidate on a port: grant it; two candidates: grant the master not recorded in that port's last-grant register (round-robin).
REQ-018 Last-grant registers (wr_last, rd_last) SHALL update on every granted transfer to the granted master index; unchanged otherwise.
REQ-019 Grants SHALL be combinational in the request cycle; at most one gnt per master per cycle; gnt SHALL be 0 when req is 0.
REQ-020 Granted write: ram_w_en=1, ram_w_addr/ram_w_data = granted master's addr/wdata, same cycle.
REQ-021 Granted read: ram_r_en=1, ram_r_addr = granted master's addr, same cycle; owner index registered.
REQ-022 Read latency SHALL be exactly 1 cycle: rvalid high for one cycle on the owning master only, the cycle after grant.
REQ-023 rdata SHALL equal ram_r_data during rvalid, unless bypass applies (REQ-024); mNrdata is don't-care when rvalid is 0.
REQ-024 Bypass: read and write granted same cycle to same address -> wdata registered and returned as rdata next cycle (new data, not stale RAM data).
REQ-025 Back-to-back reads SHALL sustain one per cycle; owner/bypass registers are rewritten each granted read.
REQ-026 ram_w_en and ram_r_en SHALL be 0 whenever no grant on that port.
REQ-027 When no master is granted, ram addr/data outputs SHALL be driven from master 0 inputs (no latches).

Reset
REQ-028 While rst_n=0: all gnt=0, ram_w_en=0, ram_r_en=0, all rvalid=0, irrespective of requests.
REQ-029 Reset values: wr_last=1, rd_last=1 (master 0 wins first contention), owner=0, bypass flag=0, bypass data=0.
REQ-030 Reset asserted the cycle after a read grant SHALL suppress that rvalid; no response after deassertion.
REQ-031 First grant possible in the first cycle rst_n is high.

Verification
REQ-032 m0 write addr 0x010 data 0xDEADBEEF, next cycle m0 read 0x010 -> m0_gnt both cycles; m0_rvalid one cycle later with 0xDEADBEEF, m1_rvalid=0.
REQ-033 After reset, m0 and m1 both read (0x001, 0x002) for 3 cycles -> grant order m0, m1, m0; rvalid alternates one cycle later with matching data.
REQ-034 Same cycle m0 write 0x020=0x12345678, m1 read 0x020 (old 0x0) -> both granted; m1_rdata=0x12345678 next cycle.
REQ-035 Same cycle m0 read 0x030, m1 write 0x031 -> both granted; m0_rdata = prior RAM content of 0x030, 0x031 updated.
REQ-036 m1 read granted, rst_n low next cycle -> m1_rvalid stays 0; all gnt/en 0 during reset; m0 wins first contention after release.
REQ-037 Continuous m1 read requests with m0 idle for 8 cycles -> m1 granted every cycle, 8 rvalid pulses, no gaps.
